// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch sequencer and next-PC controller for the unpipelined core.
// Each instruction makes one instruction-memory request and waits for its ack.
// Next PC is chosen from the exception, jump, branch or sequential source.
// Optional feature macro: PC_EXC_EN enables the exception redirect and o_epc.
module pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_0000),
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(32'h0000_0020)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    input  logic            i_imem_ack,
    output logic [PC_W-1:0] o_pc,
    output logic            o_instr_valid,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic [15:0]     i_branch_off,
    input  logic            i_jump,
    input  logic [25:0]     i_jump_tgt,
    input  logic            i_exc,
    output logic [PC_W-1:0] o_epc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic            req_reg;
    logic            valid_reg;
    logic [PC_W-1:0] pc1;
    logic [PC_W-1:0] pc_next;
    logic            exc_take;

    assign pc1 = pc_reg + PC_W'(1);

`ifdef PC_EXC_EN
    logic [PC_W-1:0] epc_reg;
    assign exc_take = i_exc;
    assign o_epc    = epc_reg;
`else
    // Exception input and vector have no effect in this build.
    logic unused_exc;
    assign unused_exc = i_exc ^ (^EXC_VEC);
    assign exc_take   = 1'b0;
    assign o_epc      = '0;
`endif

    // Next-PC selection: exception over jump over branch over sequential.
    always_comb begin
        pc_next = pc1;
        if (i_branch_taken) begin
            pc_next = pc1 + {{(PC_W-16){i_branch_off[15]}}, i_branch_off};
        end
        if (i_jump) begin
            pc_next = {pc1[PC_W-1:26], i_jump_tgt};
        end
        if (exc_take) begin
            pc_next = EXC_VEC;
        end
    end

    // Fetch/execute state machine; all outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            req_reg   <= 1'b0;
            valid_reg <= 1'b0;
`ifdef PC_EXC_EN
            epc_reg   <= '0;
`endif
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    state_reg <= FETCH;
                    req_reg   <= 1'b1;
                end
                FETCH: begin
                    if (i_imem_ack) begin
                        req_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    // A stall freezes the PC and masks every redirect source.
                    if (!i_stall) begin
                        pc_reg    <= pc_next;
                        req_reg   <= 1'b1;
                        state_reg <= FETCH;
`ifdef PC_EXC_EN
                        if (exc_take) begin
                            epc_reg <= pc_reg;
                        end
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = pc_reg;
    assign o_imem_req    = req_reg;
    assign o_instr_valid = valid_reg;

endmodule
